pe_ctrl_1st: RTL and testbench

PE_CTRL_1ST -- requirements
Module: pe_ctrl_1st

---
 rtl/pe_ctrl_1st.sv | 117 +++++++++++
 tb/tb_pe_ctrl_1st.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctrl_1st.sv
// rtl/pe_ctrl_1st.sv - sequencer for one PE MAC pass: flush, tap reads, accumulate, result pulse
// Every output is a register, updated on the same edge as the state it belongs to.
module pe_ctrl_1st #(
    parameter int MAX_TAPS = 25,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_taps_i,
    input  logic              abort,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pe_en,
    output logic              pe_flush,
    output logic              res_valid,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_N    = (ADDR_W+1)'(MAX_TAPS);
    localparam logic [ADDR_W:0]   ONE_N    = 1;
    localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

    state_t          state;
    logic [ADDR_W:0] n_taps;
    logic            pe_d1;
    logic            drain_cnt;
    logic            last_tap;

    assign last_tap = ({1'b0, rd_addr} == (n_taps - ONE_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_taps    <= '0;
            pe_d1     <= 1'b0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            pe_en     <= 1'b0;
            pe_flush  <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Two-stage delay matches buffer read latency plus the PE product register.
            pe_d1     <= rd_en;
            pe_en     <= pe_d1;
            pe_flush  <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && (num_taps_i != '0)) begin
                        n_taps   <= (num_taps_i > MAX_N) ? MAX_N : num_taps_i;
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        pe_flush <= 1'b1;
                    end
                end
                CLEAR, RUN, DRAIN: begin
                    if (abort) begin
                        // Cancelled pass: wipe the accumulator and anything still in flight.
                        state    <= IDLE;
                        busy     <= 1'b0;
                        rd_en    <= 1'b0;
                        rd_addr  <= '0;
                        pe_d1    <= 1'b0;
                        pe_en    <= 1'b0;
                        pe_flush <= 1'b1;
                    end else if (state == CLEAR) begin
                        state   <= RUN;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end else if (state == RUN) begin
                        if (last_tap) begin
                            state     <= DRAIN;
                            rd_en     <= 1'b0;
                            rd_addr   <= '0;
                            drain_cnt <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + ONE_ADDR;
                        end
                    end else begin
                        if (drain_cnt) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctrl_1st.sv
// tb/tb_pe_ctrl_1st.sv - self-checking bench for pe_ctrl_1st with buffer/PE model and pass-offset reference
module tb_pe_ctrl_1st;

    localparam int MAX_TAPS = 25;
    localparam int ADDR_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   num_taps_i;
    logic              abort;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pe_en;
    logic              pe_flush;
    logic              res_valid;
    logic              done;

    always #5 clk = ~clk;

    pe_ctrl_1st #(.MAX_TAPS(MAX_TAPS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_taps_i (num_taps_i),
        .abort      (abort),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .pe_en      (pe_en),
        .pe_flush   (pe_flush),
        .res_valid  (res_valid),
        .done       (done)
    );

    // Weight/pixel buffers with 1-cycle read latency, product register, accumulator.
    logic signed [7:0]  wbuf [32];
    logic signed [7:0]  pbuf [32];
    logic signed [7:0]  w_q, p_q;
    logic signed [15:0] prod;
    logic signed [31:0] acc;

    always @(posedge clk) begin
        if (rd_en) begin
            w_q <= wbuf[rd_addr];
            p_q <= pbuf[rd_addr];
        end
        prod <= w_q * p_q;
        if (pe_flush)
            acc <= 0;
        else if (pe_en)
            acc <= acc + prod;
    end

    logic [10:0] dut_out;
    assign dut_out = {busy, rd_en, rd_addr, pe_en, pe_flush, res_valid, done};

    int vectors     = 0;
    int miscompares = 0;

    // Reference: a pass is described only by its cycle offset k from acceptance (k=1 is CLEAR).
    bit m_active = 1'b0;
    bit m_aflush = 1'b0;
    int m_k      = 0;
    int m_n      = 0;
    int m_sum    = 0;
    int last_acc = 0;

    function automatic logic [10:0] mk(input logic b, input logic r, input int a,
                                       input logic pe, input logic f, input logic rv);
        return {b, r, 5'(a), pe, f, rv, rv};
    endfunction

    function automatic logic [10:0] model_out();
        if (!m_active)
            return mk(1'b0, 1'b0, 0, 1'b0, m_aflush, 1'b0);
        return mk(m_k <= m_n + 3,
                  (m_k >= 2) && (m_k <= m_n + 1),
                  ((m_k >= 2) && (m_k <= m_n + 1)) ? m_k - 2 : 0,
                  (m_k >= 4) && (m_k <= m_n + 3),
                  m_k == 1,
                  m_k == m_n + 4);
    endfunction

    task automatic model_edge(input logic s, input logic [5:0] num, input logic a);
        if (m_active) begin
            if (m_k == m_n + 4) begin
                m_active = 1'b0;
                m_aflush = 1'b0;
            end else if (a) begin
                m_active = 1'b0;
                m_aflush = 1'b1;
            end else begin
                m_k++;
            end
        end else begin
            m_aflush = 1'b0;
            if (s && num != 6'd0) begin
                m_active = 1'b1;
                m_k      = 1;
                m_n      = (num > 6'd25) ? 25 : int'(num);
                m_sum    = 0;
                for (int i = 0; i < m_n; i++)
                    m_sum += int'(wbuf[i]) * int'(pbuf[i]);
            end
        end
    endtask

    // Called just after a rising edge: drive, sample at the falling edge, advance model at the next rise.
    task automatic step(input logic s, input logic [5:0] num, input logic a, output logic [10:0] got);
        logic [10:0] exp;
        #1;
        start      = s;
        num_taps_i = num;
        abort      = a;
        @(negedge clk);
        got = dut_out;
        exp = model_out();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL model k=%0d n=%0d: got %b required %b", m_k, m_n, got, exp);
        end
        if (got[0] === 1'b1)
            last_acc = acc;
        if (exp[0]) begin
            vectors++;
            if (acc !== m_sum) begin
                miscompares++;
                $display("FAIL pe_sum: got %0d required %0d", acc, m_sum);
            end
        end
        @(posedge clk);
        model_edge(s, num, a);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    typedef struct {
        logic        s;
        logic [5:0]  num;
        logic        a;
        logic [10:0] exp;
    } vec_t;

    vec_t        tbl [14];
    logic [10:0] got;
    int          cnt_a, cnt_b, cyc_done;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_taps_i = '0;
        for (int i = 0; i < 32; i++) begin
            wbuf[i] = 8'sd1;
            pbuf[i] = 8'sd1;
        end

        #12;
        check_int("reset_outputs", int'(dut_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // N=1 pass, start in DONE, start with N=0, start+abort in IDLE, abort in RUN.
        tbl[0]  = '{1'b1, 6'd1, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 6'd1, 1'b0, mk(1, 0, 0, 0, 1, 0)};
        tbl[2]  = '{1'b0, 6'd1, 1'b0, mk(1, 1, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, 6'd1, 1'b0, mk(1, 0, 0, 0, 0, 0)};
        tbl[4]  = '{1'b0, 6'd1, 1'b0, mk(1, 0, 0, 1, 0, 0)};
        tbl[5]  = '{1'b1, 6'd1, 1'b0, mk(0, 0, 0, 0, 0, 1)};
        tbl[6]  = '{1'b0, 6'd1, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b1, 6'd0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{1'b0, 6'd0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1'b1, 6'd2, 1'b1, mk(0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b0, 6'd2, 1'b0, mk(1, 0, 0, 0, 1, 0)};
        tbl[11] = '{1'b0, 6'd2, 1'b1, mk(1, 1, 0, 0, 0, 0)};
        tbl[12] = '{1'b0, 6'd2, 1'b0, mk(0, 0, 0, 0, 1, 0)};
        tbl[13] = '{1'b0, 6'd2, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].num, tbl[i].a, got);
            vectors++;
            if (got !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL table[%0d]: got %b required %b", i, got, tbl[i].exp);
            end
        end

        // Nominal 25-tap pass with unit data.
        cnt_a = 0; cnt_b = 0; cyc_done = -1;
        for (int c = 0; c < 32; c++) begin
            step(c == 0, 6'd25, 1'b0, got);
            if (got[9]) cnt_a++;
            if (got[3]) cnt_b++;
            if (got[0]) cyc_done = c;
        end
        check_int("nominal_rd_en_cycles", cnt_a, 25);
        check_int("nominal_pe_en_cycles", cnt_b, 25);
        check_int("nominal_done_cycle", cyc_done, 29);
        check_int("nominal_sum", last_acc, 25);

        // Oversized tap count clamps to MAX_TAPS.
        cnt_a = 0;
        for (int c = 0; c < 32; c++) begin
            step(c == 0, 6'd31, 1'b0, got);
            if (got[9]) cnt_a++;
        end
        check_int("clamp_rd_en_cycles", cnt_a, 25);

        // Start held high: a new pass every 8 cycles.
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 24; c++) begin
            step(1'b1, 6'd3, 1'b0, got);
            if (got[0]) cnt_a++;
            if (got[2]) cnt_b++;
        end
        check_int("b2b_done_count", cnt_a, 3);
        check_int("b2b_flush_count", cnt_b, 3);
        for (int c = 0; c < 8; c++) step(1'b0, 6'd3, 1'b0, got);

        // Signed data through the PE.
        wbuf[0] = -8'sd128; pbuf[0] = -8'sd128;
        wbuf[1] =  8'sd127; pbuf[1] = -8'sd1;
        last_acc = 0;
        for (int c = 0; c < 8; c++) step(c == 0, 6'd2, 1'b0, got);
        check_int("signed_sum", last_acc, 16257);
        for (int i = 0; i < 2; i++) begin
            wbuf[i] = 8'sd1;
            pbuf[i] = 8'sd1;
        end

        // Abort while rd_addr is 10, then a clean pass.
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 12; c++) step(c == 0, 6'd25, 1'b0, got);
        step(1'b0, 6'd25, 1'b1, got);
        check_int("abort_addr", int'(got[8:4]), 10);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 6'd25, 1'b0, got);
            if (got[0]) cnt_a++;
            if (got[3]) cnt_b++;
        end
        check_int("abort_no_done", cnt_a, 0);
        check_int("abort_no_pe_en", cnt_b, 0);
        cnt_a = 0;
        for (int c = 0; c < 32; c++) begin
            step(c == 0, 6'd25, 1'b0, got);
            if (got[0]) cnt_a++;
        end
        check_int("after_abort_done", cnt_a, 1);

        // Asynchronous reset between edges in RUN.
        for (int c = 0; c < 8; c++) step(c == 0, 6'd10, 1'b0, got);
        #3;
        rst_n = 1'b0;
        #1;
        check_int("async_reset_outputs", int'(dut_out), 0);
        m_active = 1'b0;
        m_aflush = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        cnt_a = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 6'd10, 1'b0, got);
            if (got[0]) cnt_a++;
        end
        check_int("reset_no_done", cnt_a, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 32; i++) begin
            wbuf[i] = 8'($urandom);
            pbuf[i] = 8'($urandom);
        end
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 3) == 0, 6'($urandom_range(0, 63)),
                 $urandom_range(0, 39) == 0, got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
